// File: rtl/fp32_pkg.sv
// Shared constants, FSM state encoding and operand classification for the
// float32 2*pi range reducer and related fixed-to-float stages.
package fp32_pkg;

    // 2*pi in unsigned Q3.29, the modulus of the reduction.
    localparam logic [31:0] TWO_PI_Q  = 32'hC90FDAA2;
    // Fraction bits of the residue format. The datapath shifts assume 29.
    localparam int          FRAC_BITS = 29;
    localparam logic [31:0] QNAN_F32  = 32'h7FC00000;
    localparam logic [7:0]  EXP_BIAS  = 8'd127;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // SPECIAL: Inf/NaN. SMALL: |x| < 1, passed through unchanged.
    // ONE: |x| in [1,2), already below 2*pi. LARGE: needs doubling steps.
    typedef enum logic [1:0] {
        CLS_SPECIAL = 2'd0,
        CLS_SMALL   = 2'd1,
        CLS_ONE     = 2'd2,
        CLS_LARGE   = 2'd3
    } opclass_t;

    function automatic opclass_t classify(input logic [7:0] e);
        opclass_t c;
        if (e == 8'hFF) begin
            c = CLS_SPECIAL;
        end else if (e < EXP_BIAS) begin
            c = CLS_SMALL;
        end else if (e == EXP_BIAS) begin
            c = CLS_ONE;
        end else begin
            c = CLS_LARGE;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp32_norm_q329.sv
// Combinational Q3.29 -> float32 conversion (sign always 0).
// Leading-one detect, left-justify, truncate the mantissa to 23 bits.
module fp32_norm_q329
    import fp32_pkg::*;
(
    input  logic [31:0] q_in,
    output logic [31:0] f_out
);

    logic [4:0]  lead_s;
    logic [23:0] top_s;
    logic [7:0]  exp_s;

    // Find the index of the highest set bit; higher indices override lower ones.
    always_comb begin
        lead_s = 5'd0;
        for (int i = 0; i < 32; i++) begin
            lead_s = q_in[i] ? 5'(i) : lead_s;
        end
    end

    // Left-justify so the leading one lands on bit 31; keep the top 24 bits.
    // top_s[23] doubles as the nonzero flag since a zero input stays zero.
    always_comb begin
        top_s = 24'((q_in << (5'd31 - lead_s)) >> 8);
        exp_s = {3'b000, lead_s} + (EXP_BIAS - 8'(FRAC_BITS));
        if (top_s[23]) begin
            f_out = {1'b0, exp_s, top_s[22:0]};
        end else begin
            f_out = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/fp_range_reduce_2pi.sv
// float32 argument reducer: y = |x| mod 2*pi, one exponent step per cycle.
// The mantissa is loaded as a Q3.29 residue and doubled modulo 2*pi once per
// unit of unbiased exponent, then renormalised back to float32.
module fp_range_reduce_2pi
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_out,
    output logic        out_invalid
);

    state_t      state_r, state_nxt_s;
    logic [32:0] r_r;
    logic [7:0]  cnt_r;
    logic        bypass_r;
    logic [31:0] bypass_val_r;
    logic        invalid_r;
    logic        out_valid_r;
    logic [31:0] y_out_r;
    logic        out_invalid_r;

    logic        accept_s;
    opclass_t    cls_s;
    logic [32:0] t_s;
    logic [32:0] step_s;
    logic [31:0] norm_y_s;

    assign accept_s = in_valid && (state_r == IDLE);
    assign cls_s    = classify(x_in[30:23]);

    // Residue is always below 2*pi, so bit 32 of the doubled value is the carry
    // of bit 31 and the shift never loses information.
    assign t_s    = r_r << 1;
    assign step_s = (t_s >= {1'b0, TWO_PI_Q}) ? (t_s - {1'b0, TWO_PI_Q}) : t_s;

    fp32_norm_q329 u_norm (
        .q_in  (r_r[31:0]),
        .f_out (norm_y_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (cls_s == CLS_LARGE) begin
                        state_nxt_s = REDUCE;
                    end else begin
                        state_nxt_s = NORM;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REDUCE: begin
                if (cnt_r == 8'd1) begin
                    state_nxt_s = NORM;
                end else begin
                    state_nxt_s = REDUCE;
                end
            end
            NORM: begin
                state_nxt_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath: capture/classify on accept, doubling steps, output load and release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r           <= 33'd0;
            cnt_r         <= 8'd0;
            bypass_r      <= 1'b0;
            bypass_val_r  <= 32'h0000_0000;
            invalid_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            y_out_r       <= 32'h0000_0000;
            out_invalid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        case (cls_s)
                            CLS_SPECIAL: begin
                                bypass_r     <= 1'b1;
                                bypass_val_r <= QNAN_F32;
                                invalid_r    <= 1'b1;
                            end
                            CLS_SMALL: begin
                                bypass_r     <= 1'b1;
                                bypass_val_r <= {1'b0, x_in[30:0]};
                                invalid_r    <= 1'b0;
                            end
                            default: begin
                                bypass_r  <= 1'b0;
                                invalid_r <= 1'b0;
                                // {1,M} placed so the hidden one sits at bit 29 (value 1.0).
                                r_r       <= {3'b000, 1'b1, x_in[22:0], 6'b000000};
                                cnt_r     <= x_in[30:23] - EXP_BIAS;
                            end
                        endcase
                    end
                end
                REDUCE: begin
                    r_r   <= step_s;
                    cnt_r <= cnt_r - 8'd1;
                end
                NORM: begin
                    y_out_r       <= bypass_r ? bypass_val_r : norm_y_s;
                    out_invalid_r <= invalid_r;
                    out_valid_r   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r   <= 1'b0;
                        out_invalid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = out_valid_r;
    assign y_out       = y_out_r;
    assign out_invalid = out_invalid_r;

endmodule

// File: tb/tb_fp_range_reduce_2pi.sv
// Self-checking bench for fp_range_reduce_2pi: directed vector table, stall and
// mid-operation reset sequences, and random operands against an arithmetic model.
module tb_fp_range_reduce_2pi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y_out;
    logic        out_invalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_range_reduce_2pi dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_in        (x_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y_out       (y_out),
        .out_invalid (out_invalid)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        inv;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: |x| mod 2*pi computed with integer modulo on the Q3.29 value.
    function automatic void model(input logic [31:0] x, output logic [31:0] y,
                                  output logic inv, output int lat);
        longint two_pi = 64'hC90FDAA2;
        longint r;
        longint frac;
        longint mant;
        int     e;
        int     n;
        int     p;
        e   = int'(x[30:23]);
        inv = 1'b0;
        if (e == 255) begin
            y   = 32'h7FC00000;
            inv = 1'b1;
            lat = 1;
        end else if (e < 127) begin
            y   = {1'b0, x[30:0]};
            lat = 1;
        end else begin
            n = e - 127;
            r = (longint'(x[22:0]) + 64'd8388608) * 64;
            for (int k = 0; k < n; k++) r = (r * 2) % two_pi;
            lat = n + 1;
            if (r == 0) begin
                y = 32'h0;
            end else begin
                p = 0;
                for (int i = 0; i < 32; i++) if (((r >> i) & 1) == 1) p = i;
                frac = r - (64'd1 << p);
                mant = (p >= 23) ? (frac >> (p - 23)) : (frac << (23 - p));
                y = 32'(((p + 98) << 23) + mant);
            end
        end
    endfunction

    // One complete operation: wait for in_ready, handshake in, time out_valid, take the result.
    task automatic run_op(input logic [31:0] x, output logic [31:0] y, output logic inv,
                          output int lat, output bit ok);
        int k;
        ok  = 1'b0;
        lat = 0;
        y   = 32'h0;
        inv = 1'b0;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        x_in     = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = $urandom;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 300);
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        y         = y_out;
        inv       = out_invalid;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b1;
    endtask

    vec_t        vecs[6];
    logic [31:0] got_y;
    logic [31:0] exp_y;
    logic        got_inv;
    logic        exp_inv;
    int          got_lat;
    int          exp_lat;
    bit          ok;
    bit          seen;

    initial begin
        vecs[0] = '{x: 32'h3F800000, y: 32'h3F800000, inv: 1'b0, lat: 1};
        vecs[1] = '{x: 32'h40E00000, y: 32'h3F37812A, inv: 1'b0, lat: 3};
        vecs[2] = '{x: 32'h40C90FDB, y: 32'h343C0000, inv: 1'b0, lat: 3};
        vecs[3] = '{x: 32'hBF800000, y: 32'h3F800000, inv: 1'b0, lat: 1};
        vecs[4] = '{x: 32'h3E000000, y: 32'h3E000000, inv: 1'b0, lat: 1};
        vecs[5] = '{x: 32'h7F800000, y: 32'h7FC00000, inv: 1'b1, lat: 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_y_out", y_out, 32'h0);
        check("reset_out_invalid", 32'(out_invalid), 32'd0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].x, got_y, got_inv, got_lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_y", i), got_y, vecs[i].y);
                check($sformatf("vec%0d_inv", i), 32'(got_inv), 32'(vecs[i].inv));
                check($sformatf("vec%0d_lat", i), 32'(got_lat), 32'(vecs[i].lat));
                check($sformatf("vec%0d_released", i), 32'(out_valid), 32'd0);
            end
        end

        // Backpressure: result held 20 cycles while a second operand is offered.
        @(negedge clk);
        x_in     = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        check("stall_first_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 20; k++) begin
            x_in     = 32'h40E00000;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("stall_y_stable", y_out, 32'h3F800000);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("stall_second_not_captured", 32'(seen), 32'd0);

        // Reset in the middle of a long reduction drops the operation.
        @(negedge clk);
        x_in     = 32'h7E967699;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midop_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midop_rst_valid", 32'(out_valid), 32'd0);
        check("midop_rst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midop_dropped", 32'(seen), 32'd0);
        run_op(32'h3F800000, got_y, got_inv, got_lat, ok);
        if (ok) begin
            check("post_rst_y", got_y, 32'h3F800000);
            check("post_rst_lat", 32'(got_lat), 32'd1);
        end

        // Random operands, exponents biased toward short reductions.
        for (int t = 0; t < 1500; t++) begin
            logic [31:0] x;
            int sel;
            x   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 1) begin
                x[30:23] = 8'hFF;
            end else if (sel == 2) begin
                x[30:23] = 8'($urandom_range(200, 254));
            end else if (sel >= 3) begin
                x[30:23] = 8'($urandom_range(118, 150));
            end
            model(x, exp_y, exp_inv, exp_lat);
            run_op(x, got_y, got_inv, got_lat, ok);
            if (ok) begin
                check($sformatf("rand_y x=%h", x), got_y, exp_y);
                check($sformatf("rand_inv x=%h", x), 32'(got_inv), 32'(exp_inv));
                check($sformatf("rand_lat x=%h", x), 32'(got_lat), 32'(exp_lat));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
